color_code_monitor: RTL and testbench
=====================================

Name: color_code_monitor

Overview:
- Receive-side decoder for the 2-bit Moore output code of the Blue/Red colour state machine (2'h1 = Blue, 2'h2 = Red).
- Sits downstream of that FSM. Rebuilds its state from the observed code stream and regenerates the toggle command that caused each transition.
- Counts transitions and measures dwell time per state.
- Flags illegal codes and excessive dwell for debug and status logic.

Parameters:
- CNT_WIDTH, 8, width of each transition counter.
- DWELL_WIDTH, 8, width of the dwell counter.
- MAX_DWELL, 200, dwell threshold in valid samples that raises timeout; must satisfy 1 <= MAX_DWELL <= 2^DWELL_WIDTH-1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- code_valid  input  1  code is sampled on this cycle.
- code  input  2  observed colour code.
- clr  input  1  synchronous clear of counters, error and state.
- state_out  output  2  tracked state: 0=SYNC, 1=BLUE, 2=RED, 3=ERROR.
- toggle  output  1  one-cycle pulse when a colour transition is detected.
- cmd_recon  output  2  reconstructed command: 2'h1 on the toggle cycle, otherwise 2'h0.
- b2r_count  output  CNT_WIDTH  number of Blue->Red transitions.
- r2b_count  output  CNT_WIDTH  number of Red->Blue transitions.
- dwell  output  DWELL_WIDTH  valid samples spent in the current colour since entry.
- timeout  output  1  one-cycle pulse when dwell reaches MAX_DWELL.
- err  output  1  sticky illegal-code flag.
- err_code  output  2  offending code captured at the first error.

Behaviour:
- Reset: rst=1 asynchronously forces state_out=SYNC, toggle=0, cmd_recon=0, b2r_count=0, r2b_count=0, dwell=0, timeout=0, err=0, err_code=0.
- Timing: all outputs are registered. The input sampled at rising edge k is reflected on the outputs after edge k (1-cycle latency).
- Priority: rst > clr > code_valid.
- clr=1 (any state):
  - next state SYNC; counters, dwell, err and err_code go to 0; toggle=0, timeout=0.
  - code is ignored that cycle.
- code_valid=0: state, counters and dwell hold; toggle=0, cmd_recon=0, timeout=0.
- Legal codes are 2'h1 and 2'h2. Codes 2'h0 and 2'h3 are illegal.
- FSM on code_valid=1:
  - SYNC:
    - code 1 -> BLUE; code 2 -> RED.
    - dwell=0, no toggle, counters unchanged (acquisition is not a transition).
  - BLUE:
    - code 1 -> stay; dwell increments, saturating at MAX_DWELL.
    - code 2 -> RED; toggle=1, cmd_recon=1, b2r_count+1, dwell=0.
  - RED:
    - code 2 -> stay; dwell increments, saturating at MAX_DWELL.
    - code 1 -> BLUE; toggle=1, cmd_recon=1, r2b_count+1, dwell=0.
  - ERROR: absorbing. Valid codes are ignored and all counters hold. Only clr or rst leave ERROR.
  - Illegal code in SYNC, BLUE or RED:
    - next state ERROR, err=1, err_code=code.
    - dwell=0, no toggle, counters hold.
- Transition counters wrap modulo 2^CNT_WIDTH (255 -> 0 at the default width); no overflow flag.
- Timeout:
  - Pulses timeout=1 for exactly one cycle on the edge where dwell goes MAX_DWELL-1 -> MAX_DWELL.
  - dwell then stays at MAX_DWELL with no further pulse until dwell is reset by a transition, clr, error or rst.
  - With MAX_DWELL=1, the pulse occurs on the first stay sample.
- A transition and a timeout never occur in the same cycle, because a transition resets dwell.
- Mid-operation rst: immediate. The next valid code after release is treated as SYNC acquisition and does not count as a transition.

Test Plan:
- Acquire: reset, then code_valid=1 with code=2 for 1 cycle -> state_out=2, toggle=0, b2r=r2b=0, dwell=0.
- Toggling: from RED, drive code sequence 1,2,1 -> toggle pulses on 3 consecutive cycles, cmd_recon=1 each time, r2b_count=2, b2r_count=1, dwell=0.
- Dwell/timeout with MAX_DWELL=4:
  - from BLUE, hold code=1 for 6 valid cycles -> dwell 1,2,3,4,4,4; timeout high only on the cycle dwell becomes 4.
  - Interleaving code_valid=0 cycles freezes dwell.
- Illegal code: from BLUE drive code=3 -> state_out=3, err=1, err_code=3. Subsequent codes 2,1 leave counters unchanged. clr=1 -> SYNC with err=0, err_code=0, counters 0.
- Wrap: with CNT_WIDTH=8, perform 256 Blue->Red transitions -> b2r_count returns to 0. clr asserted with code=2 in the same cycle -> code ignored, state SYNC.
- Async reset: assert rst between edges while in RED with b2r_count=5 -> outputs go to reset values before the next edge. After release, code=1 -> BLUE with no toggle and counters 0.

Source files
------------

// File: rtl/color_code_monitor.sv
// color_code_monitor
//
// Receive-side decoder for the 2-bit Moore output code of the Blue/Red colour
// state machine (2'h1 = Blue, 2'h2 = Red). It rebuilds the upstream FSM state
// from the sampled code stream and regenerates the toggle command behind each
// colour change. It also counts transitions, measures dwell time per colour,
// and flags illegal codes and excessive dwell.
//
// Ports:
//   clk        clock
//   rst        asynchronous, active-high reset
//   code_valid code is sampled on this cycle
//   code       observed colour code
//   clr        synchronous clear of counters, error and state (beats code_valid)
//   state_out  tracked state: 0=SYNC, 1=BLUE, 2=RED, 3=ERROR
//   toggle     one-cycle pulse on a detected colour transition
//   cmd_recon  reconstructed command: 2'h1 on the toggle cycle, else 2'h0
//   b2r_count  Blue->Red transition count (wraps)
//   r2b_count  Red->Blue transition count (wraps)
//   dwell      valid samples spent in the current colour since entry (saturates)
//   timeout    one-cycle pulse when dwell reaches MAX_DWELL
//   err        sticky illegal-code flag
//   err_code   offending code captured at the first error
//
// All outputs are registered; an input sampled at edge k appears after edge k.

module color_code_monitor #(
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned DWELL_WIDTH = 8,
  parameter int unsigned MAX_DWELL   = 200
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   code_valid,
  input  logic [1:0]             code,
  input  logic                   clr,
  output logic [1:0]             state_out,
  output logic                   toggle,
  output logic [1:0]             cmd_recon,
  output logic [CNT_WIDTH-1:0]   b2r_count,
  output logic [CNT_WIDTH-1:0]   r2b_count,
  output logic [DWELL_WIDTH-1:0] dwell,
  output logic                   timeout,
  output logic                   err,
  output logic [1:0]             err_code
);

  typedef enum logic [1:0] {
    StSync  = 2'd0,
    StBlue  = 2'd1,
    StRed   = 2'd2,
    StError = 2'd3
  } state_e;

  localparam logic [DWELL_WIDTH-1:0] DwellMax = DWELL_WIDTH'(MAX_DWELL);
  localparam logic [CNT_WIDTH-1:0]   CntOne   = CNT_WIDTH'(1);
  localparam logic [DWELL_WIDTH-1:0] DwellOne = DWELL_WIDTH'(1);

  state_e state_q;
  logic   code_legal;

  assign code_legal = (code == 2'h1) || (code == 2'h2);

  // The state encoding matches the published state_out encoding directly.
  assign state_out = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StSync;
      toggle    <= 1'b0;
      cmd_recon <= 2'h0;
      b2r_count <= '0;
      r2b_count <= '0;
      dwell     <= '0;
      timeout   <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'h0;
    end else begin
      // Pulse outputs default low; only a sampled transition/threshold raises them.
      toggle    <= 1'b0;
      cmd_recon <= 2'h0;
      timeout   <= 1'b0;

      if (clr) begin
        state_q   <= StSync;
        b2r_count <= '0;
        r2b_count <= '0;
        dwell     <= '0;
        err       <= 1'b0;
        err_code  <= 2'h0;
      end else if (code_valid) begin
        unique case (state_q)
          StSync: begin
            if (code_legal) begin
              // Acquisition: adopt the observed colour, not a transition.
              state_q <= state_e'(code);
              dwell   <= '0;
            end else begin
              state_q  <= StError;
              err      <= 1'b1;
              err_code <= code;
              dwell    <= '0;
            end
          end

          StBlue, StRed: begin
            if (!code_legal) begin
              state_q  <= StError;
              err      <= 1'b1;
              err_code <= code;
              dwell    <= '0;
            end else if (code == state_q) begin
              // Stay: count up to the threshold, pulse once on reaching it.
              if (dwell < DwellMax) begin
                dwell   <= dwell + DwellOne;
                timeout <= (dwell == DwellMax - DwellOne);
              end
            end else begin
              toggle    <= 1'b1;
              cmd_recon <= 2'h1;
              dwell     <= '0;
              if (state_q == StBlue) begin
                state_q   <= StRed;
                b2r_count <= b2r_count + CntOne;
              end else begin
                state_q   <= StBlue;
                r2b_count <= r2b_count + CntOne;
              end
            end
          end

          StError: begin
            // Absorbing until clr or rst.
          end

          default: begin
            state_q <= StError;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_color_code_monitor.sv
module tb_color_code_monitor;

  localparam int MAXD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       code_valid;
  logic [1:0] code;
  logic       clr;
  logic [1:0] state_out;
  logic       toggle;
  logic [1:0] cmd_recon;
  logic [7:0] b2r_count;
  logic [7:0] r2b_count;
  logic [7:0] dwell;
  logic       timeout;
  logic       err;
  logic [1:0] err_code;

  color_code_monitor #(
    .CNT_WIDTH  (8),
    .DWELL_WIDTH(8),
    .MAX_DWELL  (MAXD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .code_valid(code_valid),
    .code      (code),
    .clr       (clr),
    .state_out (state_out),
    .toggle    (toggle),
    .cmd_recon (cmd_recon),
    .b2r_count (b2r_count),
    .r2b_count (r2b_count),
    .dwell     (dwell),
    .timeout   (timeout),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: colour tracker built from the behavioural rules,
  // using plain integers (state 0=SYNC,1=BLUE,2=RED,3=ERROR).
  int m_state, m_b2r, m_r2b, m_dwell, m_ec;
  bit m_tog, m_tmo, m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 0; m_b2r <= 0; m_r2b <= 0; m_dwell <= 0;
      m_ec <= 0; m_tog <= 0; m_tmo <= 0; m_err <= 0;
    end else begin
      m_tog <= 0;
      m_tmo <= 0;
      if (clr) begin
        m_state <= 0; m_b2r <= 0; m_r2b <= 0; m_dwell <= 0; m_err <= 0; m_ec <= 0;
      end else if (code_valid) begin
        if (m_state == 3) begin
          // error is absorbing
        end else if (!(code == 2'd1 || code == 2'd2)) begin
          m_state <= 3; m_err <= 1; m_ec <= int'(code); m_dwell <= 0;
        end else if (m_state == 0) begin
          m_state <= int'(code); m_dwell <= 0;
        end else if (int'(code) == m_state) begin
          if (m_dwell < MAXD) begin
            m_dwell <= m_dwell + 1;
            m_tmo   <= (m_dwell + 1 == MAXD);
          end
        end else begin
          m_tog   <= 1;
          m_dwell <= 0;
          m_state <= int'(code);
          if (m_state == 1) m_b2r <= (m_b2r + 1) % 256;
          else              m_r2b <= (m_r2b + 1) % 256;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("state", int'(state_out), m_state);
      check("toggle", int'(toggle), int'(m_tog));
      check("cmd_recon", int'(cmd_recon), m_tog ? 1 : 0);
      check("b2r", int'(b2r_count), m_b2r);
      check("r2b", int'(r2b_count), m_r2b);
      check("dwell", int'(dwell), m_dwell);
      check("timeout", int'(timeout), int'(m_tmo));
      check("err", int'(err), int'(m_err));
      check("err_code", int'(err_code), m_ec);
    end
  end

  // Apply inputs now, then advance one edge; returns 1 time unit after the edge.
  task automatic step(input bit v, input logic [1:0] c, input bit cl);
    code_valid = v;
    code       = c;
    clr        = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; code_valid = 1'b0; code = 2'd0; clr = 1'b0;
    #12 rst = 1'b0;
    @(posedge clk); #1;
    cmp_on = 1'b1;

    // Reset state
    check("rst_state", int'(state_out), 0);
    check("rst_dwell", int'(dwell), 0);
    check("rst_err", int'(err), 0);

    // Acquire RED
    step(1, 2'd2, 0);
    check("acq_state", int'(state_out), 2);
    check("acq_toggle", int'(toggle), 0);
    check("acq_b2r", int'(b2r_count), 0);
    check("acq_dwell", int'(dwell), 0);

    // Toggling 1,2,1
    step(1, 2'd1, 0);
    check("tg1", int'(toggle), 1);
    step(1, 2'd2, 0);
    check("tg2", int'(cmd_recon), 1);
    step(1, 2'd1, 0);
    check("tg3", int'(toggle), 1);
    check("tg_r2b", int'(r2b_count), 2);
    check("tg_b2r", int'(b2r_count), 1);
    check("tg_dwell", int'(dwell), 0);

    // Dwell/timeout from BLUE with invalid samples interleaved
    for (int i = 1; i <= 6; i++) begin
      step(1, 2'd1, 0);
      check("dw_val", int'(dwell), (i < MAXD) ? i : MAXD);
      check("dw_tmo", int'(timeout), (i == MAXD) ? 1 : 0);
      step(0, 2'd2, 0);
      check("dw_hold", int'(dwell), (i < MAXD) ? i : MAXD);
      check("dw_hold_tmo", int'(timeout), 0);
    end

    // Illegal code
    step(1, 2'd3, 0);
    check("il_state", int'(state_out), 3);
    check("il_err", int'(err), 1);
    check("il_ec", int'(err_code), 3);
    step(1, 2'd2, 0);
    step(1, 2'd1, 0);
    check("il_b2r", int'(b2r_count), 1);
    check("il_r2b", int'(r2b_count), 2);
    check("il_state2", int'(state_out), 3);
    step(0, 2'd0, 1);
    check("clr_state", int'(state_out), 0);
    check("clr_err", int'(err), 0);
    check("clr_ec", int'(err_code), 0);
    check("clr_r2b", int'(r2b_count), 0);

    // Counter wrap
    step(1, 2'd1, 0);
    for (int i = 0; i < 256; i++) begin
      step(1, 2'd2, 0);
      if (i == 254) check("wrap_255", int'(b2r_count), 255);
      step(1, 2'd1, 0);
    end
    check("wrap_b2r", int'(b2r_count), 0);
    check("wrap_r2b", int'(r2b_count), 0);
    step(1, 2'd2, 1);
    check("clr_code_ign", int'(state_out), 0);

    // Asynchronous reset while in RED with b2r=5
    step(1, 2'd1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 2'd2, 0);
      if (i < 4) step(1, 2'd1, 0);
    end
    check("ar_pre_b2r", int'(b2r_count), 5);
    check("ar_pre_state", int'(state_out), 2);
    #1 rst = 1'b1;
    #1;
    check("ar_state", int'(state_out), 0);
    check("ar_b2r", int'(b2r_count), 0);
    check("ar_r2b", int'(r2b_count), 0);
    #1 rst = 1'b0;
    step(1, 2'd1, 0);
    check("ar_acq_state", int'(state_out), 1);
    check("ar_acq_toggle", int'(toggle), 0);
    check("ar_acq_b2r", int'(b2r_count), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit       v;
      bit       cl;
      logic [1:0] c;
      v  = ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 9) < 8) ? (($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2)
                                      : 2'($urandom_range(0, 3));
      cl = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      step(v, c, cl);
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
